mdu_iter: RTL and testbench
===========================

# mdu_iter

Iterative multiply/divide unit for the EX stage of the pipelined MIPS core, sitting beside the combinational ALU and owning the HI/LO register pair. It accepts mult/multu/div/divu/mthi/mtlo commands with a start/busy handshake, holds HI/LO stable until a fixed-latency operation completes, and serves mfhi/mflo reads combinationally. The hazard unit stalls D-stage on `Start | Busy` for any instruction that needs the MDU.

## Interface
- MULT_CYCLES, 5, cycles Busy stays high for mult/multu (≥1)
- DIV_CYCLES, 10, cycles Busy stays high for div/divu (≥1)
- clk  in  1  core clock, all state changes on rising edge
- reset_n  in  1  reset; synchronous, active-low
- In0  in  32  rs operand (dividend / multiplicand / mthi, mtlo data)
- In1  in  32  rt operand (divisor / multiplier)
- MDUOp  in  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo, others none
- Start  in  1  one-cycle command strobe, meaningful for MDUOp 1–6 only
- Busy  out  1  registered; high while an operation is in flight
- HI  out  32  current HI register
- LO  out  32  current LO register
- Res  out  32  mfhi → HI, mflo → LO, otherwise 0; combinational

## Operation
- States: IDLE, RUN. Reset: IDLE, Busy=0, HI=0, LO=0, counter=0, pending result=0.
- IDLE + Start + MDUOp 1/2: compute 64-bit product (signed for 1, unsigned for 2) into pending HI/LO, load counter=MULT_CYCLES, Busy←1, go RUN.
- IDLE + Start + MDUOp 3/4: pending LO=quotient, HI=remainder (signed for 3, unsigned for 4); load counter=DIV_CYCLES, Busy←1, go RUN.
- Signed divide: quotient truncates toward zero; remainder takes dividend's sign. 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- Divisor 0: operation still runs full DIV_CYCLES; at completion HI/LO are left unchanged.
- IDLE + Start + MDUOp 5/6: HI (5) or LO (6) ← In0 at that edge; no Busy.
- RUN: counter decrements each cycle; on the edge where counter==1, commit pending HI/LO, Busy←0, go IDLE.
- Start in RUN: ignored entirely (hazard unit guarantees it does not happen; block must not corrupt state if it does).
- Start with MDUOp 0, 7, 8 or undefined: no state change.
- HI/LO outputs show committed values only; never partial/pending results.

## Timing
- Start at cycle T (mult): Busy=1 during T+1…T+MULT_CYCLES; HI/LO new and Busy=0 at T+MULT_CYCLES+1. Same with DIV_CYCLES for div.
- Back-to-back: a new Start is accepted in the first cycle Busy reads 0.
- mthi/mtlo at T: visible on HI/LO and through Res at T+1.
- Res has zero latency from MDUOp/HI/LO.
- reset_n low at any edge, including mid-RUN: returns to reset values that edge; pending result discarded; Start on the same edge ignored.

## Configuration
- MDU_DIV_EN defined: div/divu supported as above.
- MDU_DIV_EN undefined: no divider logic synthesized; MDUOp 3/4 with Start treated as none (Busy stays 0, HI/LO unchanged); mult/mthi/mtlo/mf unaffected.

## Test plan
- Reset, then mult In0=0xFFFFFFFD (−3), In1=7 → Busy high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFEB; multu same operands → HI=0x00000006, LO=0xFFFFFFEB.
- divu 100/7 → after 10 Busy cycles LO=14, HI=2; div 0xFFFFFFF9 (−7)/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- mthi 0x12345678, then div 5/0 → HI stays 0x12345678 after 10 cycles, Busy drops normally; Res with mfhi = 0x12345678.
- mult 2×3, Start pulsed again with mtlo 0xAA at cycle 2 of Busy → ignored; final LO=6, HI=0.
- div started, reset_n low at Busy cycle 4 → next cycle Busy=0, HI=LO=0, no later commit.
- MDU_DIV_EN undefined: div 9/3 with Start → Busy never rises, HI/LO unchanged.

Source files
------------

// File: rtl/mdu_iter.sv
// Fixed-latency multiply/divide unit that owns the HI/LO register pair.
// The divider is built only when MDU_DIV_EN is defined; otherwise div/divu are treated as no-ops.
module mdu_iter #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [31:0] In0,
   input  logic [31:0] In1,
   input  logic [3:0]  MDUOp,
   input  logic        Start,
   output logic        Busy,
   output logic [31:0] HI,
   output logic [31:0] LO,
   output logic [31:0] Res
);

   localparam int CMAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW   = $clog2(CMAX + 1);

   typedef enum logic [0:0] {IDLE, RUN} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          busy_q, busy_d;
   logic [31:0]   hi_q, hi_d, lo_q, lo_d;
   logic [31:0]   pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
   logic          pend_ok_q, pend_ok_d;

   logic [63:0]   prod_s;
   logic [31:0]   div_q_s, div_r_s;

   // 64-bit product; sign extension to 64 bits gives the signed result for mult
   always_comb begin
      if (MDUOp == 4'd1) begin
         prod_s = {{32{In0[31]}}, In0} * {{32{In1[31]}}, In1};
      end else begin
         prod_s = {32'd0, In0} * {32'd0, In1};
      end
   end

`ifdef MDU_DIV_EN
   localparam bit DIV_EN = 1'b1;
   logic        div_signed_s, neg_a_s, neg_b_s;
   logic [31:0] mag_a_s, mag_b_s, uq_s, ur_s;

   // Divide on magnitudes, then restore signs; this also handles 0x80000000 / -1 without overflow
   always_comb begin
      div_signed_s = (MDUOp == 4'd3);
      neg_a_s      = div_signed_s & In0[31];
      neg_b_s      = div_signed_s & In1[31];
      mag_a_s      = neg_a_s ? (32'd0 - In0) : In0;
      mag_b_s      = neg_b_s ? (32'd0 - In1) : In1;
      if (mag_b_s == 32'd0) begin
         uq_s = 32'd0;
         ur_s = 32'd0;
      end else begin
         uq_s = mag_a_s / mag_b_s;
         ur_s = mag_a_s % mag_b_s;
      end
      div_q_s = (neg_a_s ^ neg_b_s) ? (32'd0 - uq_s) : uq_s;
      div_r_s = neg_a_s ? (32'd0 - ur_s) : ur_s;
   end
`else
   localparam bit DIV_EN = 1'b0;
   assign div_q_s = 32'd0;
   assign div_r_s = 32'd0;
`endif

   // Next-state: command acceptance in IDLE, countdown and commit in RUN
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      busy_d    = busy_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      pend_hi_d = pend_hi_q;
      pend_lo_d = pend_lo_q;
      pend_ok_d = pend_ok_q;
      case (state_q)
         IDLE: begin
            if (Start) begin
               case (MDUOp)
                  4'd1, 4'd2: begin
                     pend_hi_d = prod_s[63:32];
                     pend_lo_d = prod_s[31:0];
                     pend_ok_d = 1'b1;
                     cnt_d     = CW'(MULT_CYCLES);
                     busy_d    = 1'b1;
                     state_d   = RUN;
                  end
                  4'd3, 4'd4: begin
                     if (DIV_EN) begin
                        pend_hi_d = div_r_s;
                        pend_lo_d = div_q_s;
                        pend_ok_d = (In1 != 32'd0);
                        cnt_d     = CW'(DIV_CYCLES);
                        busy_d    = 1'b1;
                        state_d   = RUN;
                     end else begin
                        state_d = IDLE;
                     end
                  end
                  4'd5:    hi_d = In0;
                  4'd6:    lo_d = In0;
                  default: state_d = IDLE;
               endcase
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            if (cnt_q == CW'(1)) begin
               if (pend_ok_q) begin
                  hi_d = pend_hi_q;
                  lo_d = pend_lo_q;
               end else begin
                  hi_d = hi_q;
               end
               cnt_d   = {CW{1'b0}};
               busy_d  = 1'b0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         cnt_q     <= {CW{1'b0}};
         busy_q    <= 1'b0;
         hi_q      <= 32'd0;
         lo_q      <= 32'd0;
         pend_hi_q <= 32'd0;
         pend_lo_q <= 32'd0;
         pend_ok_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         busy_q    <= busy_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         pend_hi_q <= pend_hi_d;
         pend_lo_q <= pend_lo_d;
         pend_ok_q <= pend_ok_d;
      end
   end

   // mfhi/mflo read path
   always_comb begin
      case (MDUOp)
         4'd7:    Res = hi_q;
         4'd8:    Res = lo_q;
         default: Res = 32'd0;
      endcase
   end

   assign Busy = busy_q;
   assign HI   = hi_q;
   assign LO   = lo_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Directed plus randomized bench for mdu_iter against a plain-arithmetic HI/LO model.
// Expectations for div/divu follow MDU_DIV_EN exactly as the design does.
module tb_mdu_iter;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [31:0] In0 = 32'd0, In1 = 32'd0;
   logic [3:0]  MDUOp = 4'd0;
   logic        Start = 1'b0;
   logic        Busy;
   logic [31:0] HI, LO, Res;

   int checks = 0;
   int errors = 0;
   logic [31:0] m_hi = 32'd0, m_lo = 32'd0;

`ifdef MDU_DIV_EN
   localparam bit DIV_EN = 1'b1;
`else
   localparam bit DIV_EN = 1'b0;
`endif

   mdu_iter #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk(clk), .reset_n(reset_n), .In0(In0), .In1(In1), .MDUOp(MDUOp),
      .Start(Start), .Busy(Busy), .HI(HI), .LO(LO), .Res(Res)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: new {HI,LO} and busy length for one command, from the arithmetic rules
   task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat);
      longint q, r, p;
      lat = 0;
      case (op)
         4'd1: begin p = longint'($signed(a)) * longint'($signed(b)); m_hi = p[63:32]; m_lo = p[31:0]; lat = 5; end
         4'd2: begin p = longint'({32'd0, a}) * longint'({32'd0, b}); m_hi = p[63:32]; m_lo = p[31:0]; lat = 5; end
         4'd3, 4'd4: begin
            if (DIV_EN) begin
               lat = 10;
               if (b != 32'd0) begin
                  if (op == 4'd3) begin
                     q = longint'($signed(a)) / longint'($signed(b));
                     r = longint'($signed(a)) % longint'($signed(b));
                  end else begin
                     q = longint'({32'd0, a}) / longint'({32'd0, b});
                     r = longint'({32'd0, a}) % longint'({32'd0, b});
                  end
                  m_lo = q[31:0];
                  m_hi = r[31:0];
               end
            end
         end
         4'd5: m_hi = a;
         4'd6: m_lo = a;
         default: lat = 0;
      endcase
   endtask

   // Pulse Start for one cycle; returns at the negedge after the accepting edge
   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      MDUOp = op; In0 = a; In1 = b; Start = 1'b1;
      @(negedge clk);
      Start = 1'b0; MDUOp = 4'd0;
   endtask

   // Count busy cycles (bounded) while checking HI/LO never show pending values
   task automatic wait_idle(input string tag, input logic [31:0] old_hi, input logic [31:0] old_lo,
                            output int n);
      n = 0;
      while (Busy === 1'b1 && n < 40) begin
         if (HI !== old_hi || LO !== old_lo) begin
            chk({tag, "_hold_hi"}, HI, old_hi);
            chk({tag, "_hold_lo"}, LO, old_lo);
         end
         n++;
         @(negedge clk);
      end
   endtask

   task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] oh, ol;
      int lat, n;
      oh = m_hi; ol = m_lo;
      model(op, a, b, lat);
      issue(op, a, b);
      wait_idle(tag, oh, ol, n);
      chk({tag, "_busy_len"}, 32'(n), 32'(lat));
      chk({tag, "_hi"}, HI, m_hi);
      chk({tag, "_lo"}, LO, m_lo);
   endtask

   task automatic check_res(input string tag);
      MDUOp = 4'd7; #1;
      chk({tag, "_mfhi"}, Res, m_hi);
      MDUOp = 4'd8; #1;
      chk({tag, "_mflo"}, Res, m_lo);
      MDUOp = 4'd0; #1;
      chk({tag, "_res_none"}, Res, 32'd0);
   endtask

   initial begin
      int n, lat;
      logic [3:0] op;
      logic [31:0] a, b;

      // Reset with a stray mthi on the reset edges
      MDUOp = 4'd5; In0 = 32'hDEADBEEF; Start = 1'b1;
      repeat (2) @(negedge clk);
      Start = 1'b0; MDUOp = 4'd0; reset_n = 1'b1;
      chk("rst_busy", {31'd0, Busy}, 32'd0);
      chk("rst_hi", HI, 32'd0);
      chk("rst_lo", LO, 32'd0);

      run_op("mult", 4'd1, 32'hFFFFFFFD, 32'd7);
      run_op("multu", 4'd2, 32'hFFFFFFFD, 32'd7);
      chk("multu_hi_const", HI, 32'h00000006);
      chk("multu_lo_const", LO, 32'hFFFFFFEB);
      run_op("divu", 4'd4, 32'd100, 32'd7);
      run_op("div", 4'd3, 32'hFFFFFFF9, 32'd2);
      run_op("div_ovf", 4'd3, 32'h80000000, 32'hFFFFFFFF);
      run_op("mthi", 4'd5, 32'h12345678, 32'd0);
      run_op("div0", 4'd3, 32'd5, 32'd0);
      check_res("div0");
      run_op("div9_3", 4'd3, 32'd9, 32'd3);

      // Start during RUN must be ignored
      model(4'd1, 32'd2, 32'd3, lat);
      issue(4'd1, 32'd2, 32'd3);
      @(negedge clk);
      MDUOp = 4'd6; In0 = 32'hAA; Start = 1'b1;
      @(negedge clk);
      Start = 1'b0; MDUOp = 4'd0;
      wait_idle("ign", HI, LO, n);
      chk("ign_remaining", 32'(n), 32'd3);
      chk("ign_hi", HI, 32'd0);
      chk("ign_lo", LO, 32'd6);

      // Back-to-back: new command in first idle cycle
      run_op("b2b", 4'd2, 32'd4, 32'd5);

      // Reset in the middle of a long operation
      issue(DIV_EN ? 4'd4 : 4'd1, 32'd1000, 32'd3);
      repeat (3) @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      m_hi = 32'd0; m_lo = 32'd0;
      chk("mrst_busy", {31'd0, Busy}, 32'd0);
      chk("mrst_hi", HI, 32'd0);
      chk("mrst_lo", LO, 32'd0);
      repeat (12) @(negedge clk);
      chk("mrst_nocommit_lo", LO, 32'd0);
      chk("mrst_nocommit_busy", {31'd0, Busy}, 32'd0);

      // Randomized commands, including no-op opcodes and zero divisors
      for (int i = 0; i < 40; i++) begin
         op = 4'($urandom_range(0, 15));
         a  = $urandom;
         b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
         if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 9));
         run_op($sformatf("rnd%0d_op%0d", i, op), op, a, b);
         check_res($sformatf("rnd%0d", i));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
